// File: rtl/shift_arb_ctrl.sv
// shift_arb_ctrl: round-robin front end for a shared 64-bit left-only
// logarithmic shifter. Right shifts are built by bit-reversing around the
// left shift; SRA and ROL take a second pass through the same shifter.

module shift_arb_ctrl_shifter #(
  parameter int W  = 64,
  parameter int AW = 6
) (
  input  logic [W-1:0]  din,
  input  logic [AW-1:0] amt,
  output logic [W-1:0]  dout
);

  logic [W-1:0] stage;

  // Log shifter: stage i shifts left by 2^i when amount bit i is set
  always_comb begin
    stage = din;
    for (int i = 0; i < AW; i++) begin
      if (amt[i]) stage = stage << (1 << i);
    end
    dout = stage;
  end

endmodule

module shift_arb_ctrl #(
  parameter int W  = 64,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [W-1:0]  req0_data,
  input  logic [AW-1:0] req0_amt,
  input  logic [1:0]    req0_op,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [W-1:0]  req1_data,
  input  logic [AW-1:0] req1_amt,
  input  logic [1:0]    req1_op,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [W-1:0]  resp_data,
  output logic          resp_id
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef enum logic [1:0] {IDLE, PASS2, HOLD} state_t;

  state_t        state, state_next;
  logic          rr_last;
  logic [W-1:0]  op_data;
  logic [AW-1:0] op_amt;
  logic [1:0]    op_op;
  logic          op_id;
  logic [W-1:0]  p1;

  logic          grant_any, grant_id;
  logic [W-1:0]  sel_data;
  logic [AW-1:0] sel_amt;
  logic [1:0]    sel_op;
  logic          sel_right, two_pass;
  logic [W-1:0]  sh_in, sh_out;
  logic [AW-1:0] sh_amt;
  logic [W-1:0]  pass1_result, pass2_result;

  function automatic logic [W-1:0] bitrev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  // Round-robin grant, only offered in IDLE and never while reset is held
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (state == IDLE && !rst) begin
      if (req0_valid && req1_valid) begin
        grant_any = 1'b1;
        grant_id  = ~rr_last;
      end else if (req0_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b0;
      end else if (req1_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign req0_ready = grant_any && !grant_id;
  assign req1_ready = grant_any && grant_id;

  assign sel_data  = grant_id ? req1_data : req0_data;
  assign sel_amt   = grant_id ? req1_amt  : req0_amt;
  assign sel_op    = grant_id ? req1_op   : req0_op;
  assign sel_right = (sel_op == OP_SRL) || (sel_op == OP_SRA);
  assign two_pass  = ((sel_op == OP_SRA) || (sel_op == OP_ROL)) && (sel_amt != '0);

  // Shifter input steering: pass 1 in IDLE, mask or wrap-around bits in PASS2
  always_comb begin
    sh_in  = '0;
    sh_amt = '0;
    if (state == IDLE) begin
      sh_in  = sel_right ? bitrev(sel_data) : sel_data;
      sh_amt = sel_amt;
    end else if (state == PASS2) begin
      if (op_op == OP_SRA) begin
        sh_in  = '1;
        sh_amt = op_amt;
      end else begin
        sh_in  = bitrev(op_data);
        sh_amt = '0 - op_amt;
      end
    end
  end

  shift_arb_ctrl_shifter #(.W(W), .AW(AW)) u_shifter (
    .din  (sh_in),
    .amt  (sh_amt),
    .dout (sh_out)
  );

  // Result forming around the shared shifter for both passes
  always_comb begin
    pass1_result = sel_right ? bitrev(sh_out) : sh_out;
    if (op_op == OP_SRA)
      pass2_result = p1 | (op_data[W-1] ? ~bitrev(sh_out) : '0);
    else
      pass2_result = p1 | bitrev(sh_out);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next state: accept in IDLE, optional second pass, hold until taken
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_any) state_next = two_pass ? PASS2 : HOLD;
      PASS2:   state_next = HOLD;
      HOLD:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, arbitration history and the registered response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last    <= 1'b1;
      op_data    <= '0;
      op_amt     <= '0;
      op_op      <= OP_SLL;
      op_id      <= 1'b0;
      p1         <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            rr_last <= grant_id;
            op_data <= sel_data;
            op_amt  <= sel_amt;
            op_op   <= sel_op;
            op_id   <= grant_id;
            if (two_pass) begin
              p1 <= pass1_result;
            end else begin
              resp_data  <= pass1_result;
              resp_id    <= grant_id;
              resp_valid <= 1'b1;
            end
          end
        end
        PASS2: begin
          resp_data  <= pass2_result;
          resp_id    <= op_id;
          resp_valid <= 1'b1;
        end
        HOLD: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: resp_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_arb_ctrl.sv
// Testbench for shift_arb_ctrl: directed vectors, reset/arbitration/backpressure
// sequences and a full op x amount sweep against an arithmetic reference model.

module tb_shift_arb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [63:0] req0_data, req1_data;
  logic [5:0]  req0_amt, req1_amt;
  logic [1:0]  req0_op, req1_op;
  logic        resp_valid, resp_ready, resp_id;
  logic [63:0] resp_data;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        id;
    logic [1:0]  op;
    logic [63:0] data;
    logic [5:0]  amt;
    logic [63:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vectors[10];

  shift_arb_ctrl dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_amt(req0_amt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_amt(req1_amt), .req1_op(req1_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id)
  );

  always #5 clk = ~clk;

  // Reference: the four operations straight from their arithmetic definitions
  function automatic logic [63:0] model_result(input logic [1:0] op, input logic [63:0] d,
                                               input logic [5:0] a);
    logic signed [63:0] s;
    s = d;
    case (op)
      2'b00:   return d << a;
      2'b01:   return d >> a;
      2'b10:   return s >>> a;
      default: return (a == 6'd0) ? d : ((d << a) | (d >> (64 - int'(a))));
    endcase
  endfunction

  function automatic int model_latency(input logic [1:0] op, input logic [5:0] a);
    return (op[1] && a != 6'd0) ? 2 : 1;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h", name, actual, expected);
    end
  endtask

  task automatic drive_req(input logic id, input logic valid, input logic [1:0] op,
                           input logic [63:0] data, input logic [5:0] amt);
    if (id) begin
      req1_valid = valid; req1_op = op; req1_data = data; req1_amt = amt;
    end else begin
      req0_valid = valid; req0_op = op; req0_data = data; req0_amt = amt;
    end
  endtask

  // Issue one op, wait (bounded) for accept and response, then take the response
  task automatic run_op(input logic id, input logic [1:0] op, input logic [63:0] data,
                        input logic [5:0] amt, output logic [63:0] got_data,
                        output logic got_id, output int got_lat);
    bit accepted = 0;
    got_data = '0; got_id = 1'b0; got_lat = 0;
    drive_req(id, 1'b1, op, data, amt);
    for (int c = 0; c < 20 && !accepted; c++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) accepted = 1;
      else @(posedge clk);
    end
    if (!accepted) begin
      checks++; errors++;
      $display("[TB] FAIL accept_timeout: got ready=0 expected ready=1 (id=%0d)", id);
      drive_req(id, 1'b0, op, data, amt);
      return;
    end
    @(posedge clk); #1;
    drive_req(id, 1'b0, op, data, amt);
    got_lat = 1;
    while (!resp_valid && got_lat < 6) begin
      @(posedge clk); #1;
      got_lat++;
    end
    got_data = resp_data;
    got_id   = resp_id;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    logic [63:0] d;
    logic        i;
    int          l;
    run_op(v.id, v.op, v.data, v.amt, d, i, l);
    checkOutput({tag, "_data"}, d, v.exp_data);
    checkOutput({tag, "_id"}, 64'(i), 64'(v.id));
    checkOutput({tag, "_lat"}, 64'(l), 64'(v.exp_lat));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] a_data, b_data, c_data, d_data, got_d;
    logic        got_i;
    int          got_l, grants, exp_grant;
    logic        grant_q[$];
    logic        gid;

    vectors[0] = '{1'b0, 2'b00, 64'h1, 6'd63, 64'h8000_0000_0000_0000, 1};
    vectors[1] = '{1'b1, 2'b01, 64'h8000_0000_0000_00F0, 6'd4, 64'h0800_0000_0000_000F, 1};
    vectors[2] = '{1'b1, 2'b10, 64'h8000_0000_0000_00F0, 6'd4, 64'hF800_0000_0000_000F, 2};
    vectors[3] = '{1'b0, 2'b10, 64'h7FFF_FFFF_FFFF_FFFF, 6'd63, 64'h0, 2};
    vectors[4] = '{1'b0, 2'b11, 64'h8000_0000_0000_0001, 6'd1, 64'h3, 2};
    vectors[5] = '{1'b1, 2'b11, 64'h8000_0000_0000_0001, 6'd0, 64'h8000_0000_0000_0001, 1};
    vectors[6] = '{1'b0, 2'b10, 64'h8000_0000_0000_00F0, 6'd0, 64'h8000_0000_0000_00F0, 1};
    vectors[7] = '{1'b1, 2'b10, 64'h8000_0000_0000_0000, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 2};
    vectors[8] = '{1'b0, 2'b11, 64'h1, 6'd63, 64'h8000_0000_0000_0000, 2};
    vectors[9] = '{1'b1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 64'h1, 1};

    rst = 1'b1; resp_ready = 1'b0;
    drive_req(1'b0, 1'b1, 2'b00, 64'h5, 6'd1);
    drive_req(1'b1, 1'b0, 2'b00, 64'h0, 6'd0);
    #12;
    checkOutput("reset_resp_valid", 64'(resp_valid), 64'h0);
    checkOutput("reset_resp_data", resp_data, 64'h0);
    checkOutput("reset_resp_id", 64'(resp_id), 64'h0);
    checkOutput("reset_readys", 64'({req0_ready, req1_ready}), 64'h0);
    req0_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] directed vectors");
    for (int k = 0; k < 10; k++) applyStimulus(vectors[k], $sformatf("vec%0d", k));

    $display("[TB] reset during HOLD");
    drive_req(1'b0, 1'b1, 2'b00, 64'h1, 6'd63);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    checkOutput("hold_resp_valid", 64'(resp_valid), 64'h1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_resp_valid", 64'(resp_valid), 64'h0);
    checkOutput("async_rst_resp_data", resp_data, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] reset during PASS2");
    @(posedge clk); #1;
    drive_req(1'b1, 1'b1, 2'b10, 64'h8000_0000_0000_00F0, 6'd4);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("pass2_rst_no_resp", 64'(resp_valid), 64'h0);
    end

    $display("[TB] round-robin arbitration");
    do_reset();
    a_data = 64'h0123_4567_89AB_CDEF;
    b_data = 64'hFEDC_BA98_7654_3210;
    resp_ready = 1'b1;
    drive_req(1'b0, 1'b1, 2'b00, a_data, 6'd3);
    drive_req(1'b1, 1'b1, 2'b01, b_data, 6'd5);
    grants = 0; exp_grant = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (req0_ready && req1_ready)
        checkOutput("double_grant", 64'({req0_ready, req1_ready}), 64'h1);
      if (resp_valid && resp_ready) begin
        if (grant_q.size() == 0) begin
          checkOutput("unexpected_resp", 64'(resp_valid), 64'h0);
        end else begin
          gid = grant_q.pop_front();
          checkOutput("arb_resp_id", 64'(resp_id), 64'(gid));
          checkOutput("arb_resp_data", resp_data,
                      gid ? model_result(2'b01, b_data, 6'd5) : model_result(2'b00, a_data, 6'd3));
        end
      end
      if (req0_ready ^ req1_ready) begin
        gid = req1_ready;
        checkOutput("arb_grant_order", 64'(gid), 64'(exp_grant));
        grant_q.push_back(gid);
        exp_grant = 1 - exp_grant;
        grants++;
      end
      if (c == 23) begin
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
    end
    checkOutput("arb_grant_count", 64'(grants), 64'd12);
    checkOutput("arb_queue_drained", 64'(grant_q.size()), 64'd0);
    resp_ready = 1'b0;
    @(posedge clk); #1;

    $display("[TB] backpressure");
    c_data = 64'h0000_0000_DEAD_BEEF;
    d_data = 64'hF0F0_0000_0000_0F0F;
    drive_req(1'b0, 1'b1, 2'b00, c_data, 6'd8);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b1, 2'b00, 64'h77, 6'd1);
    drive_req(1'b1, 1'b1, 2'b01, d_data, 6'd2);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("bp_resp_valid", 64'(resp_valid), 64'h1);
      checkOutput("bp_resp_data", resp_data, 64'h0000_00DE_ADBE_EF00);
      checkOutput("bp_resp_id", 64'(resp_id), 64'h0);
      checkOutput("bp_readys", 64'({req0_ready, req1_ready}), 64'h0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_handshake_readys", 64'({req0_ready, req1_ready}), 64'h0);
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp_next_grant", 64'({req0_ready, req1_ready}), 64'h1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_next_resp_valid", 64'(resp_valid), 64'h1);
    checkOutput("bp_next_resp_id", 64'(resp_id), 64'h1);
    checkOutput("bp_next_resp_data", resp_data, d_data >> 2);
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;

    $display("[TB] request withdrawn before grant");
    drive_req(1'b0, 1'b1, 2'b00, 64'h3, 6'd2);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("withdrawn_no_resp", 64'(resp_valid), 64'h0);
    end
    @(posedge clk); #1;

    $display("[TB] op x amount sweep");
    for (int op = 0; op < 4; op++) begin
      for (int amt = 0; amt < 64; amt++) begin
        logic [63:0] rd;
        logic        rid;
        rd  = {$urandom, $urandom};
        rid = 1'($urandom_range(0, 1));
        run_op(rid, 2'(op), rd, 6'(amt), got_d, got_i, got_l);
        checkOutput($sformatf("sweep_op%0d_amt%0d_data", op, amt), got_d,
                    model_result(2'(op), rd, 6'(amt)));
        checkOutput($sformatf("sweep_op%0d_amt%0d_id", op, amt), 64'(got_i), 64'(rid));
        checkOutput($sformatf("sweep_op%0d_amt%0d_lat", op, amt), 64'(got_l),
                    64'(model_latency(2'(op), 6'(amt))));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
